// File: rtl/hwpe_stream_tcdm_reorder_sched.sv
// -----------------------------------------------------------------------------
// hwpe_stream_tcdm_reorder_sched
//
// Purpose:
//   Rotation scheduler for an NB_CHAN-wide TCDM reorder stage. It watches the
//   upstream per-channel req/gnt handshakes. It advances the rotation offset
//   after every fully granted round, or after STALL_TIMEOUT consecutive stalled
//   cycles, so that every channel is spread evenly over the downstream ports.
//
// Ports:
//   clk_i      clock
//   rst_i      asynchronous reset, active-high
//   clear_i    synchronous clear, same effect as reset, highest priority
//   enable_i   rotation enable; low freezes order_o
//   in_req_i   per-channel upstream request
//   in_gnt_i   per-channel upstream grant (same cycle as request)
//   order_o    rotation offset driving the reorder stage order input
//   rotate_o   one-cycle pulse in the cycle the new order_o appears
//   starve_o   one-cycle pulse marking a rotation caused by stall timeout
//   busy_o     registered FSM state, high while in BUSY
//   rot_cnt_o  saturating count of rotations since reset/clear
// -----------------------------------------------------------------------------
module hwpe_stream_tcdm_reorder_sched #(
    parameter int unsigned NB_CHAN       = 4,
    parameter int unsigned STALL_TIMEOUT = 8,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       enable_i,
    input  logic [NB_CHAN-1:0]         in_req_i,
    input  logic [NB_CHAN-1:0]         in_gnt_i,
    output logic [$clog2(NB_CHAN)-1:0] order_o,
    output logic                       rotate_o,
    output logic                       starve_o,
    output logic                       busy_o,
    output logic [CNT_W-1:0]           rot_cnt_o
);

    localparam int unsigned ORD_W = $clog2(NB_CHAN);
    // A disabled timeout still needs a legal (1-bit) counter vector.
    localparam int unsigned STALL_W = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
    localparam logic [STALL_W-1:0] STALL_LAST =
        (STALL_TIMEOUT > 0) ? STALL_W'(STALL_TIMEOUT - 1) : {STALL_W{1'b0}};
    localparam logic [CNT_W-1:0]   ROT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    logic [ORD_W-1:0]    r_order;
    logic                r_rotate;
    logic                r_starve;
    logic                r_busy;
    logic [CNT_W-1:0]    r_rot_cnt;
    logic [STALL_W-1:0]  r_stall_cnt;

    logic w_any_req;
    logic w_pend;
    logic w_full;
    logic w_timeout;
    logic w_rotate;

    // Round classification: full round, stalled round, timeout and rotation decision.
    always_comb begin
        w_any_req = |in_req_i;
        w_pend    = |(in_req_i & ~in_gnt_i);
        // A partially granted cycle is a stall, never a full round.
        w_full    = w_any_req & ~w_pend;
        w_timeout = 1'b0;
        if (STALL_TIMEOUT != 0) begin
            // Fires during the STALL_TIMEOUT-th consecutive stalled cycle.
            w_timeout = w_pend & (r_stall_cnt == STALL_LAST);
        end else begin
            w_timeout = 1'b0;
        end
        w_rotate  = enable_i & (w_full | w_timeout);
    end

    // Control FSM with registered rotation offset, pulses, stall and rotation counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_order     <= {ORD_W{1'b0}};
            r_rotate    <= 1'b0;
            r_starve    <= 1'b0;
            r_busy      <= 1'b0;
            r_rot_cnt   <= {CNT_W{1'b0}};
            r_stall_cnt <= {STALL_W{1'b0}};
        end else if (clear_i) begin
            r_state     <= ST_IDLE;
            r_order     <= {ORD_W{1'b0}};
            r_rotate    <= 1'b0;
            r_starve    <= 1'b0;
            r_busy      <= 1'b0;
            r_rot_cnt   <= {CNT_W{1'b0}};
            r_stall_cnt <= {STALL_W{1'b0}};
        end else begin
            r_rotate <= w_rotate;
            // full and timeout are exclusive, so this marks timeout-only rotations.
            r_starve <= w_rotate & w_timeout;

            if (w_rotate) begin
                // Power-of-two NB_CHAN: natural wrap from NB_CHAN-1 to 0.
                r_order <= r_order + ORD_W'(1);
                if (r_rot_cnt != ROT_MAX) begin
                    r_rot_cnt <= r_rot_cnt + CNT_W'(1);
                end else begin
                    r_rot_cnt <= r_rot_cnt;
                end
            end else begin
                r_order   <= r_order;
                r_rot_cnt <= r_rot_cnt;
            end

            if (w_rotate || !w_pend || !enable_i || (STALL_TIMEOUT == 0)) begin
                r_stall_cnt <= {STALL_W{1'b0}};
            end else begin
                r_stall_cnt <= r_stall_cnt + STALL_W'(1);
            end

            // Rotation is decided above in the same cycle as the state change.
            case (r_state)
                ST_IDLE: begin
                    if (enable_i && w_any_req) begin
                        r_state <= ST_BUSY;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (!w_any_req || !enable_i) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_BUSY;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign order_o   = r_order;
    assign rotate_o  = r_rotate;
    assign starve_o  = r_starve;
    assign busy_o    = r_busy;
    assign rot_cnt_o = r_rot_cnt;

endmodule

// File: tb/tb_hwpe_stream_tcdm_reorder_sched.sv
// -----------------------------------------------------------------------------
// tb_hwpe_stream_tcdm_reorder_sched
//
// Directed bench for the rotation scheduler. Three instances share stimulus:
// the default build, a build with the stall timeout disabled and a build with
// a 4-bit rotation counter for the saturation check.
// -----------------------------------------------------------------------------
module tb_hwpe_stream_tcdm_reorder_sched;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       enable;
    logic [3:0] req;
    logic [3:0] gnt;

    logic [1:0]  m_order;
    logic        m_rotate;
    logic        m_starve;
    logic        m_busy;
    logic [15:0] m_rot_cnt;

    logic [1:0]  n_order;
    logic        n_rotate;
    logic        n_starve;
    logic        n_busy;
    logic [15:0] n_rot_cnt;

    logic [1:0]  s_order;
    logic        s_rotate;
    logic        s_starve;
    logic        s_busy;
    logic [3:0]  s_rot_cnt;

    int n_checks;
    int n_errors;

    hwpe_stream_tcdm_reorder_sched #(.NB_CHAN(4), .STALL_TIMEOUT(8), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(enable),
        .in_req_i(req), .in_gnt_i(gnt),
        .order_o(m_order), .rotate_o(m_rotate), .starve_o(m_starve),
        .busy_o(m_busy), .rot_cnt_o(m_rot_cnt)
    );

    hwpe_stream_tcdm_reorder_sched #(.NB_CHAN(4), .STALL_TIMEOUT(0), .CNT_W(16)) u_dut_nt (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(enable),
        .in_req_i(req), .in_gnt_i(gnt),
        .order_o(n_order), .rotate_o(n_rotate), .starve_o(n_starve),
        .busy_o(n_busy), .rot_cnt_o(n_rot_cnt)
    );

    hwpe_stream_tcdm_reorder_sched #(.NB_CHAN(4), .STALL_TIMEOUT(8), .CNT_W(4)) u_dut_sat (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(enable),
        .in_req_i(req), .in_gnt_i(gnt),
        .order_o(s_order), .rotate_o(s_rotate), .starve_o(s_starve),
        .busy_o(s_busy), .rot_cnt_o(s_rot_cnt)
    );

    // Free-running clock, 10 time units period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks = n_checks + 1;
        if (obs !== exp_v) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    logic [1:0] exp_seq [5];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst    = 1'b1;
        clear  = 1'b0;
        enable = 1'b0;
        req    = 4'b0000;
        gnt    = 4'b0000;
        exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3;
        exp_seq[3] = 2'd0; exp_seq[4] = 2'd1;
        ticks(3);
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_order",  32'(m_order),   32'd0);
        chk("rst_rotate", 32'(m_rotate),  32'd0);
        chk("rst_starve", 32'(m_starve),  32'd0);
        chk("rst_busy",   32'(m_busy),    32'd0);
        chk("rst_rotcnt", 32'(m_rot_cnt), 32'd0);

        // Five fully granted rounds
        enable = 1'b1;
        req = 4'b1111;
        gnt = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("full_order",  32'(m_order),  32'(exp_seq[i]));
            chk("full_rotate", 32'(m_rotate), 32'd1);
            chk("full_starve", 32'(m_starve), 32'd0);
        end
        chk("full_busy",    32'(m_busy),    32'd1);
        chk("full_rotcnt",  32'(m_rot_cnt), 32'd5);
        chk("full_nt_cnt",  32'(n_rot_cnt), 32'd5);
        req = 4'b0000;
        gnt = 4'b0000;
        tick();
        chk("idle_rotate", 32'(m_rotate), 32'd0);
        chk("idle_busy",   32'(m_busy),   32'd0);
        chk("idle_order",  32'(m_order),  32'd1);

        // Partial grant held: timeout after 8 stalled cycles, then restart
        req = 4'b0011;
        gnt = 4'b0001;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("stall_rotate", 32'(m_rotate), 32'd0);
        end
        chk("stall_order", 32'(m_order), 32'd1);
        tick();
        chk("to_order",  32'(m_order),   32'd2);
        chk("to_rotate", 32'(m_rotate),  32'd1);
        chk("to_starve", 32'(m_starve),  32'd1);
        chk("to_rotcnt", 32'(m_rot_cnt), 32'd6);
        tick();
        chk("to_rotate_drop", 32'(m_rotate), 32'd0);
        chk("to_starve_drop", 32'(m_starve), 32'd0);
        ticks(6);
        chk("restart_order", 32'(m_order), 32'd2);
        tick();
        chk("to2_order",  32'(m_order),  32'd3);
        chk("to2_starve", 32'(m_starve), 32'd1);
        chk("nt_stall_order",  32'(n_order),  32'd1);
        chk("nt_stall_starve", 32'(n_starve), 32'd0);
        chk("nt_stall_rotcnt", 32'(n_rot_cnt), 32'd5);

        // Stall 5, one full round, stall 5: single rotation, no starve
        req = 4'b0000;
        gnt = 4'b0000;
        tick();
        req = 4'b0011;
        gnt = 4'b0001;
        ticks(5);
        req = 4'b1111;
        gnt = 4'b1111;
        tick();
        chk("mix_order",  32'(m_order),  32'd0);
        chk("mix_rotate", 32'(m_rotate), 32'd1);
        chk("mix_starve", 32'(m_starve), 32'd0);
        req = 4'b0011;
        gnt = 4'b0001;
        ticks(5);
        chk("mix_order_end", 32'(m_order),   32'd0);
        chk("mix_rotcnt",    32'(m_rot_cnt), 32'd8);
        chk("mix_nt_order",  32'(n_order),   32'd2);

        // Disable with full grants: frozen; re-enable resumes
        enable = 1'b0;
        req = 4'b1111;
        gnt = 4'b1111;
        ticks(3);
        chk("dis_order",  32'(m_order),   32'd0);
        chk("dis_rotate", 32'(m_rotate),  32'd0);
        chk("dis_busy",   32'(m_busy),    32'd0);
        chk("dis_rotcnt", 32'(m_rot_cnt), 32'd8);
        enable = 1'b1;
        tick();
        chk("reen_order",  32'(m_order),   32'd1);
        chk("reen_rotate", 32'(m_rotate),  32'd1);
        chk("reen_rotcnt", 32'(m_rot_cnt), 32'd9);

        // Clear during the cycle a timeout would fire
        req = 4'b0011;
        gnt = 4'b0001;
        ticks(7);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_order",  32'(m_order),   32'd0);
        chk("clr_rotate", 32'(m_rotate),  32'd0);
        chk("clr_starve", 32'(m_starve),  32'd0);
        chk("clr_busy",   32'(m_busy),    32'd0);
        chk("clr_rotcnt", 32'(m_rot_cnt), 32'd0);
        tick();
        chk("clr_after_rotate", 32'(m_rotate), 32'd0);

        // Saturation of the 4-bit counter over 20 full rounds
        req = 4'b1111;
        gnt = 4'b1111;
        ticks(15);
        chk("sat_cnt15",  32'(s_rot_cnt), 32'd15);
        tick();
        chk("sat_cnt16",  32'(s_rot_cnt), 32'd15);
        chk("sat_rotate", 32'(s_rotate),  32'd1);
        ticks(4);
        chk("sat_cnt",     32'(s_rot_cnt), 32'd15);
        chk("sat_order",   32'(s_order),   32'd0);
        chk("sat_busy",    32'(s_busy),    32'd1);
        chk("sat_starve",  32'(s_starve),  32'd0);
        chk("main_cnt20",  32'(m_rot_cnt), 32'd20);
        chk("nt_rotate",   32'(n_rotate),  32'd1);
        chk("nt_busy",     32'(n_busy),    32'd1);

        // Asynchronous reset mid-operation with order 3
        ticks(3);
        chk("pre_rst_order", 32'(m_order), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_order",  32'(m_order),   32'd0);
        chk("arst_rotate", 32'(m_rotate),  32'd0);
        chk("arst_starve", 32'(m_starve),  32'd0);
        chk("arst_busy",   32'(m_busy),    32'd0);
        chk("arst_rotcnt", 32'(m_rot_cnt), 32'd0);
        tick();
        rst = 1'b0;
        req = 4'b0000;
        gnt = 4'b0000;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
